// File: rtl/serial_frame_tx.sv
`default_nettype none
// ============================================================================
// Module      : serial_frame_tx
// Description : Serialises one frame per request onto a single line:
//               start bit (0), 2-bit port (MSB first), LEN_W-bit length
//               (MSB first), then N payload bits (LSB first), then one
//               idle-high "done" bit. All advancement is gated by clkEn.
// Ports       : clk       - system clock, rising edge
//               rst       - asynchronous active-high reset
//               clkEn     - bit-rate enable
//               Start     - frame request (sampled in IDLE only)
//               PortNum   - destination port, captured with Start
//               DataLen   - payload bit count, captured with Start
//               DataIn    - parallel payload, bit 0 sent first
//               SerOut    - serial line, idles high
//               Busy      - high in every state except IDLE
//               DataPhase - high while SerOut carries a payload bit
//               Done      - high during the closing bit of a frame
// Revision    : 1.0 - initial release
// ============================================================================
module serial_frame_tx #(
    parameter int LEN_W = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clkEn,
    input  logic                    Start,
    input  logic [1:0]              PortNum,
    input  logic [LEN_W-1:0]        DataLen,
    input  logic [(2**LEN_W)-2:0]   DataIn,
    output logic                    SerOut,
    output logic                    Busy,
    output logic                    DataPhase,
    output logic                    Done
);

    localparam int c_DATA_W = (2**LEN_W) - 1;

    localparam logic [2:0] c_S_IDLE  = 3'd0;
    localparam logic [2:0] c_S_START = 3'd1;
    localparam logic [2:0] c_S_PORT  = 3'd2;
    localparam logic [2:0] c_S_LEN   = 3'd3;
    localparam logic [2:0] c_S_DATA  = 3'd4;
    localparam logic [2:0] c_S_DONE  = 3'd5;

    localparam logic [LEN_W-1:0] c_CNT_ONE      = LEN_W'(1);
    localparam logic [LEN_W-1:0] c_CNT_LEN_LAST = LEN_W'(LEN_W - 1);

    logic [2:0]          r_state;
    logic [2:0]          w_state_nxt;
    logic [LEN_W-1:0]    r_cnt;
    logic [LEN_W-1:0]    w_cnt_nxt;
    logic [1:0]          r_port;
    logic [LEN_W-1:0]    r_len;
    logic [c_DATA_W-1:0] r_data;
    logic                w_len_bit;

    // Length field goes out MSB first; the down-counter doubles as bit index.
    assign w_len_bit = |(r_len & (c_CNT_ONE << r_cnt));

    // State, counter and captured-frame registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_S_IDLE;
            r_cnt   <= '0;
            r_port  <= '0;
            r_len   <= '0;
            r_data  <= '0;
        end else if (clkEn) begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if ((r_state == c_S_IDLE) && Start) begin
                r_port <= PortNum;
                r_len  <= DataLen;
                r_data <= DataIn;
            end else if (r_state == c_S_DATA) begin
                // Payload leaves from bit 0, so shift right each payload bit.
                r_data <= r_data >> 1;
            end
        end
    end

    // Next-state and counter reload. The counter is loaded with
    // (bits in phase - 1) on entry and the phase ends when it reads 0,
    // so it never decrements past zero.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            c_S_IDLE: begin
                if (Start) begin
                    w_state_nxt = c_S_START;
                end
            end
            c_S_START: begin
                w_state_nxt = c_S_PORT;
                w_cnt_nxt   = c_CNT_ONE;
            end
            c_S_PORT: begin
                if (r_cnt == '0) begin
                    w_state_nxt = c_S_LEN;
                    w_cnt_nxt   = c_CNT_LEN_LAST;
                end else begin
                    w_cnt_nxt = r_cnt - c_CNT_ONE;
                end
            end
            c_S_LEN: begin
                if (r_cnt == '0) begin
                    if (r_len != '0) begin
                        w_state_nxt = c_S_DATA;
                        w_cnt_nxt   = r_len - c_CNT_ONE;
                    end else begin
                        w_state_nxt = c_S_DONE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - c_CNT_ONE;
                end
            end
            c_S_DATA: begin
                if (r_cnt == '0) begin
                    w_state_nxt = c_S_DONE;
                end else begin
                    w_cnt_nxt = r_cnt - c_CNT_ONE;
                end
            end
            c_S_DONE: begin
                w_state_nxt = c_S_IDLE;
            end
            default: begin
                w_state_nxt = c_S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Moore output decode from registered state only.
    always_comb begin
        SerOut    = 1'b1;
        Busy      = 1'b1;
        DataPhase = 1'b0;
        Done      = 1'b0;
        case (r_state)
            c_S_IDLE:  Busy   = 1'b0;
            c_S_START: SerOut = 1'b0;
            c_S_PORT:  SerOut = r_port[r_cnt[0]];
            c_S_LEN:   SerOut = w_len_bit;
            c_S_DATA: begin
                SerOut    = r_data[0];
                DataPhase = 1'b1;
            end
            c_S_DONE:  Done = 1'b1;
            default:   Busy = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: doc/serial_frame_tx.md
SERIAL_FRAME_TX -- requirements
Module: serial_frame_tx

Interface
REQ-001 Parameter LEN_W, default 4: width of the length field; data field holds up to 2^LEN_W-1 bits (15 at default); only the default is verified.
REQ-002 clk  input  1  single system clock; all state changes on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 clkEn  input  1  bit-rate enable; FSM, counters and SerOut advance only on edges where clkEn=1.
REQ-005 Start  input  1  frame request; sampled only in IDLE with clkEn=1.
REQ-006 PortNum  input  2  destination port; captured with Start.
REQ-007 DataLen  input  LEN_W  number of data bits to send (0..15); captured with Start.
REQ-008 DataIn  input  2^LEN_W-1  parallel payload; bit 0 transmitted first; captured with Start.
REQ-009 SerOut  output  1  serial line; idle level 1.
REQ-010 Busy  output  1  high in every state except IDLE.
REQ-011 DataPhase  output  1  high while SerOut carries a payload bit.
REQ-012 Done  output  1  frame-complete indication.

Function
REQ-013 States: IDLE, START, PORT, LEN, DATA, DONE; all outputs are decoded from registered state, counter and shift registers (Moore, no input-to-output combinational path).
REQ-014 IDLE: SerOut=1; on clkEn=1 and Start=1, capture PortNum, DataLen, DataIn into internal registers and go to START.
REQ-015 START: SerOut=0 for one enabled cycle, then PORT.
REQ-016 PORT: SerOut = PortNum[1], then PortNum[0] (MSB first), one enabled cycle each, then LEN.
REQ-017 LEN: SerOut = DataLen[LEN_W-1] down to DataLen[0], one enabled cycle each; then DATA if captured length is nonzero, else DONE.
REQ-018 DATA: SerOut = DataIn[0], DataIn[1], ... for exactly the captured length count of enabled cycles; DataPhase=1 throughout; then DONE.
REQ-019 DONE: SerOut=1, Done=1, Busy=1 for one enabled cycle, then IDLE.
REQ-020 Frame length in enabled cycles = 1+2+LEN_W+N+1 (N = captured length); with clkEn held high, SerOut goes low one clk after the capturing edge.
REQ-021 Bit counter is a down-counter loaded at each phase entry; it must not wrap or underflow; DATA exit occurs on the cycle the counter reaches its terminal value.
REQ-022 clkEn=0: all state, counters, shift registers and outputs hold their values, including Done and DataPhase.
REQ-023 Start, PortNum, DataLen, DataIn changes while Busy=1 are ignored and do not affect the frame in flight.
REQ-024 Start held high continuously: a new frame is captured on the first enabled cycle in IDLE after DONE, i.e. back-to-back frames are separated by exactly one idle-high bit.
REQ-025 Start in DONE is not captured; capture happens only from IDLE.

Reset
REQ-026 rst=1 forces, asynchronously and regardless of clkEn: state IDLE, SerOut=1, Busy=0, DataPhase=0, Done=0, counters and captured registers 0.
REQ-027 Reset asserted mid-frame aborts the frame immediately; no Done is produced; after release the line stays 1 until a new Start.
REQ-028 First capture possible on the first enabled edge after rst deasserts.

Verification
REQ-029 clkEn=1, Start pulse with PortNum=2'b10, DataLen=4'd3, DataIn=15'h0005 -> SerOut sequence 0,1,0,0,0,1,1,1,0,1 then Done=1 with SerOut=1, Busy low next cycle; total Busy = 11 cycles.
REQ-030 DataLen=0, PortNum=2'b01 -> SerOut 0,0,1,0,0,0,0, DONE, DataPhase never high; Busy = 8 cycles.
REQ-031 clkEn pulsed 1-in-4, DataLen=15, DataIn=15'h7FFF -> each bit held exactly 4 clk, DataPhase high 60 clk, Done high 4 clk.
REQ-032 Start held high, inputs changed mid-frame -> first frame uses captured values unchanged; second frame starts after exactly one idle-high bit with new values.
REQ-033 rst asserted during DATA bit 2 of a 5-bit frame -> SerOut=1, Busy=0 immediately (before next clk edge); no Done pulse.
REQ-034 Start asserted while clkEn=0 in IDLE and deasserted before next enabled edge -> no frame; SerOut stays 1.
